// File: rtl/fpu_config_responder.sv
// fpu_config_responder: CPU-loaded configuration window that serves 512-bit
// line requests from the FPU config loader after a fixed latency.
module fpu_config_responder #(
    parameter int unsigned LINES     = 4,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_wr_en,
    input  logic [31:0]  cpu_addr,
    input  logic [31:0]  cpu_wr_data,
    output logic         busy,
    output logic         config_loaded,
    output logic         addr_err,
    output logic         load_config_start,
    input  logic         load_config_done,
    input  logic         mapped_data_request,
    input  logic [31:0]  address_mem,
    output logic         mapped_data_valid,
    output logic [511:0] data_mem
);

    localparam int unsigned WORDS = 16;
    localparam int unsigned IDX_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [25:0] LINES_L = 26'(LINES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SERVE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic             done_pend_q, done_pend_d;
    logic             loaded_q, loaded_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             start_q, start_d;
    logic             valid_q, valid_d;
    logic [511:0]     data_q, data_d;
    logic [LINES-1:0][WORDS-1:0][31:0] mem_q, mem_d;

    // CPU write decode
    logic [31:0]      cpu_off;
    logic             cpu_line_hit;
    logic             cpu_ctrl_hit;
    logic [IDX_W-1:0] cpu_line;
    logic [3:0]       cpu_word;

    // Response address decode
    logic [31:0]      resp_addr;
    logic [31:0]      rd_off;
    logic             rd_oow;
    logic [IDX_W-1:0] rd_line;

    logic unused_bits;
    assign unused_bits = ^{cpu_off[1:0], rd_off[5:0]};

    // Decode a CPU byte address into line/word or the CTRL register
    always_comb begin
        cpu_off      = cpu_addr - BASE_ADDR;
        cpu_line_hit = (cpu_addr >= BASE_ADDR) && (cpu_off[31:6] < LINES_L);
        cpu_ctrl_hit = (cpu_addr >= BASE_ADDR) && (cpu_off[31:6] == LINES_L)
                       && (cpu_off[5:2] == 4'd0);
        cpu_line     = cpu_off[6 +: IDX_W];
        cpu_word     = cpu_off[5:2];
    end

    // Decode the address the next response will be built from; with a
    // one-cycle latency the response follows acceptance directly, so the live
    // request address is used instead of the captured one.
    always_comb begin
        resp_addr = (state_q == ST_SERVE) ? address_mem : addr_q;
        rd_off    = resp_addr - BASE_ADDR;
        rd_oow    = (resp_addr < BASE_ADDR) || (rd_off[31:6] >= LINES_L);
        rd_line   = rd_off[6 +: IDX_W];
    end

    // Next-state, storage update and registered-output computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        done_pend_d = done_pend_q;
        loaded_d    = loaded_q;
        err_d       = err_q;
        mem_d       = mem_q;
        data_d      = data_q;

        case (state_q)
            ST_IDLE: begin
                if (cpu_wr_en) begin
                    if (cpu_line_hit) begin
                        mem_d[cpu_line][cpu_word] = cpu_wr_data;
                    end else if (cpu_ctrl_hit && cpu_wr_data[0]) begin
                        loaded_d = 1'b0;
                        err_d    = 1'b0;
                        state_d  = ST_START;
                    end
                end
            end
            ST_START: begin
                if (load_config_done) begin
                    done_pend_d = 1'b1;
                end
                state_d = ST_SERVE;
            end
            ST_SERVE: begin
                // Completion wins over a simultaneous request
                if (done_pend_q || load_config_done) begin
                    loaded_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (mapped_data_request) begin
                    addr_d  = address_mem;
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY <= 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (load_config_done) begin
                    done_pend_d = 1'b1;
                end
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RESP: begin
                if (load_config_done) begin
                    done_pend_d = 1'b1;
                end
                state_d = ST_SERVE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_IDLE) begin
            done_pend_d = 1'b0;
        end

        // Build the response so it is presented in the RESP cycle itself
        if (state_d == ST_RESP) begin
            if (rd_oow) begin
                data_d = '0;
                err_d  = 1'b1;
            end else begin
                data_d = mem_q[rd_line];
            end
        end

        busy_d  = (state_d != ST_IDLE);
        start_d = (state_d == ST_START);
        valid_d = (state_d == ST_RESP);
    end

    // State, storage and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            done_pend_q <= 1'b0;
            loaded_q    <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            mem_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            done_pend_q <= done_pend_d;
            loaded_q    <= loaded_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            start_q     <= start_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            mem_q       <= mem_d;
        end
    end

    assign busy              = busy_q;
    assign config_loaded     = loaded_q;
    assign addr_err          = err_q;
    assign load_config_start = start_q;
    assign mapped_data_valid = valid_q;
    assign data_mem          = data_q;

endmodule
